gf_inv_array_p: RTL and testbench

Parametrised successor to the fixed 5-bit, 4-element GF inverse array. It accepts a programmable degree and reducing polynomial, then a burst of `N` field elements. It computes each multiplicative inverse in GF(2^deg) by iterative square-and-multiply, and streams the `N` results back in input order. It sits between the input deserialiser and the result buffer of the GF datapath.

---
 rtl/gf_inv_array_p_pkg.sv | 18 +
 rtl/gf_inv_array_p_if.sv | 28 ++
 rtl/gf_inv_array_p_mul.sv | 49 ++++
 rtl/gf_inv_array_p.sv | 188 ++++++++++++++++++
 tb/tb_gf_inv_array_p.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gf_inv_array_p_pkg.sv
// Shared types and constants for the parametrised GF(2^deg) inverse array.
package gf_pkg;

  localparam int unsigned GF_MAX_DEG_DEF = 5;

  // Width of a degree field able to hold 0..max_deg.
  function automatic int unsigned DEG_W(input int unsigned max_deg);
    return $clog2(max_deg + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } gf_state_t;

endpackage

// File: rtl/gf_inv_array_p_if.sv
// Burst input / result output bundle for gf_inv_array_p.
// Carries out_err only when GF_INV_ERR_EN is defined.
interface gf_inv_array_p_if #(
  parameter int unsigned MAX_DEG = gf_pkg::GF_MAX_DEG_DEF,
  localparam int unsigned DW = gf_pkg::DEG_W(MAX_DEG)
) ();

  logic               in_valid;
  logic [MAX_DEG-1:0] in_data;
  logic [DW-1:0]      deg;
  logic [MAX_DEG:0]   poly;
  logic               out_valid;
  logic [MAX_DEG-1:0] out_data;
`ifdef GF_INV_ERR_EN
  logic               out_err;

  modport master (output in_valid, in_data, deg, poly,
                  input  out_valid, out_data, out_err);
  modport slave  (input  in_valid, in_data, deg, poly,
                  output out_valid, out_data, out_err);
`else
  modport master (output in_valid, in_data, deg, poly,
                  input  out_valid, out_data);
  modport slave  (input  in_valid, in_data, deg, poly,
                  output out_valid, out_data);
`endif

endinterface

// File: rtl/gf_inv_array_p_mul.sv
// Combinational GF(2^deg) multiplier: MSB-first shift-and-add with
// on-the-fly reduction by poly, where poly[deg] is forced to 1 and
// coefficients above deg are dropped.
module gf_mul
  import gf_pkg::*;
#(
  parameter int unsigned MAX_DEG = GF_MAX_DEG_DEF,
  localparam int unsigned DW = DEG_W(MAX_DEG)
) (
  input  logic [MAX_DEG-1:0] a,
  input  logic [MAX_DEG-1:0] b,
  input  logic [DW-1:0]      deg,
  input  logic [MAX_DEG:0]   poly,
  output logic [MAX_DEG-1:0] p
);

  logic [MAX_DEG:0]   pe;
  logic [MAX_DEG-1:0] am;
  logic [MAX_DEG-1:0] bm;
  logic [MAX_DEG:0]   r;
  logic               hi;

  // Mask operands, normalise the polynomial, then multiply-reduce.
  always_comb begin
    pe = '0;
    am = '0;
    bm = '0;
    r  = '0;
    hi = 1'b0;
    for (int k = 0; k <= int'(MAX_DEG); k++) begin
      pe[k] = (k == 32'(deg)) | (poly[k] & (k < 32'(deg)));
    end
    for (int k = 0; k < int'(MAX_DEG); k++) begin
      am[k] = a[k] & (k < 32'(deg));
      bm[k] = b[k] & (k < 32'(deg));
    end
    for (int i = int'(MAX_DEG) - 1; i >= 0; i--) begin
      r  = r << 1;
      hi = 1'b0;
      for (int k = 0; k <= int'(MAX_DEG); k++) begin
        if (k == 32'(deg)) hi = r[k];
      end
      if (hi)    r = r ^ pe;
      if (bm[i]) r = r ^ {1'b0, am};
    end
    p = r[MAX_DEG-1:0];
  end

endmodule

// File: rtl/gf_inv_array_p.sv
// Burst GF(2^deg) inverter: loads N elements, computes a^(2^deg-2) for
// each by square-and-multiply (one result register per cycle), then
// streams the N results in input order.
// Optional feature macro: GF_INV_ERR_EN (adds out_err).
module gf_inv_array_p
  import gf_pkg::*;
#(
  parameter int unsigned MAX_DEG = GF_MAX_DEG_DEF,
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst,
  gf_inv_array_p_if.slave bus
);

  localparam int unsigned DW = DEG_W(MAX_DEG);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  gf_state_t state, state_nx;

  logic [MAX_DEG-1:0] data_q [N];
  logic [MAX_DEG-1:0] res_q  [N];
  logic [DW-1:0]      deg_q;
  logic [MAX_DEG:0]   poly_q;
  logic [IW-1:0]      idx_q;
  logic [DW-1:0]      step_q;

  logic [MAX_DEG-1:0] a_cur, x, sq, prod, new_val;
  logic [DW-1:0]      s_last;
  logic               illegal, last_step, last_elem;
  logic [IW-1:0]      nidx;

  logic               valid_d, valid_r;
  logic [MAX_DEG-1:0] data_d, data_r;
`ifdef GF_INV_ERR_EN
  logic [N-1:0]       err_q;
  logic               err_new, err_d, err_r;
`endif

  function automatic logic [MAX_DEG-1:0] deg_mask(input logic [DW-1:0] d);
    logic [MAX_DEG-1:0] m;
    m = '0;
    for (int k = 0; k < int'(MAX_DEG); k++) m[k] = (k < 32'(d));
    return m;
  endfunction

  // Per-step operands and the value written into the active result slot.
  always_comb begin
    illegal   = (deg_q == '0) || (32'(deg_q) > 32'(MAX_DEG));
    s_last    = (illegal || deg_q < DW'(2)) ? '0 : deg_q - DW'(2);
    last_step = (step_q == s_last);
    last_elem = (idx_q == IW'(N - 1));
    nidx      = idx_q + IW'(1);
    a_cur     = data_q[idx_q] & deg_mask(deg_q);
    x         = (step_q == '0) ? a_cur : res_q[idx_q];
    if (illegal)                new_val = '0;
    else if (deg_q == DW'(1))   new_val = a_cur;
    else if (last_step)         new_val = sq;
    else                        new_val = prod;
  end
`ifdef GF_INV_ERR_EN
  assign err_new = illegal || (a_cur == '0);
`endif

  gf_mul #(.MAX_DEG(MAX_DEG)) u_sq (
    .a(x), .b(x), .deg(deg_q), .poly(poly_q), .p(sq)
  );

  gf_mul #(.MAX_DEG(MAX_DEG)) u_mul (
    .a(sq), .b(a_cur), .deg(deg_q), .poly(poly_q), .p(prod)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = (N == 1) ? CALC : LOAD;
      LOAD: if (!bus.in_valid || last_elem) state_nx = CALC;
      CALC: if (last_step && last_elem) state_nx = OUT;
      OUT:  if (last_elem) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next output values; the first result may be the one finishing now.
  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
`ifdef GF_INV_ERR_EN
    err_d   = 1'b0;
`endif
    case (state)
      CALC: if (last_step && last_elem) begin
        valid_d = 1'b1;
        data_d  = (idx_q == '0) ? new_val : res_q[0];
`ifdef GF_INV_ERR_EN
        err_d   = (idx_q == '0) ? err_new : err_q[0];
`endif
      end
      OUT: if (!last_elem) begin
        valid_d = 1'b1;
        data_d  = res_q[nidx];
`ifdef GF_INV_ERR_EN
        err_d   = err_q[nidx];
`endif
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
`ifdef GF_INV_ERR_EN
      err_r   <= 1'b0;
`endif
    end else begin
      valid_r <= valid_d;
      data_r  <= data_d;
`ifdef GF_INV_ERR_EN
      err_r   <= err_d;
`endif
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.out_data  = data_r;
`ifdef GF_INV_ERR_EN
  assign bus.out_err   = err_r;
`endif

  // Capture, iterate and sequence the element storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) begin
        data_q[k] <= '0;
        res_q[k]  <= '0;
      end
`ifdef GF_INV_ERR_EN
      err_q  <= '0;
`endif
      deg_q  <= '0;
      poly_q <= '0;
      idx_q  <= '0;
      step_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          deg_q     <= bus.deg;
          poly_q    <= bus.poly;
          data_q[0] <= bus.in_data;
          for (int k = 1; k < int'(N); k++) data_q[k] <= '0;
          idx_q     <= IW'((N > 1) ? 1 : 0);
          step_q    <= '0;
        end
        LOAD: begin
          if (bus.in_valid) data_q[idx_q] <= bus.in_data;
          if (!bus.in_valid || last_elem) idx_q <= '0;
          else                            idx_q <= nidx;
          step_q <= '0;
        end
        CALC: begin
          res_q[idx_q] <= new_val;
`ifdef GF_INV_ERR_EN
          err_q[idx_q] <= err_new;
`endif
          if (last_step) begin
            step_q <= '0;
            idx_q  <= last_elem ? '0 : nidx;
          end else begin
            step_q <= step_q + DW'(1);
          end
        end
        OUT: idx_q <= last_elem ? '0 : nidx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inv_array_p.sv
// Randomised self-checking bench for gf_inv_array_p (N=4/MAX_DEG=5 and
// N=1/MAX_DEG=8 instances) against a power-based GF reference model.
module tb_gf_inv_array_p;
  import gf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_inv_array_p_if #(.MAX_DEG(5)) ifa ();
  gf_inv_array_p_if #(.MAX_DEG(8)) ifb ();

  gf_inv_array_p #(.MAX_DEG(5), .N(4)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  gf_inv_array_p #(.MAX_DEG(8), .N(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int errors = 0;
  int checks = 0;
  int din [4];
  int got [4];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by polynomial long division.
  function automatic int m_mul(input int a, input int b, input int dg, input int pl);
    int prod, pf;
    prod = 0;
    for (int i = 0; i < dg; i++) if (((b >> i) & 1) != 0) prod ^= (a << i);
    pf = (pl & ((1 << dg) - 1)) | (1 << dg);
    for (int j = 2 * dg - 2; j >= dg; j--) if (((prod >> j) & 1) != 0) prod ^= (pf << (j - dg));
    return prod;
  endfunction

  // Inverse as a^(2^deg-2) by repeated multiplication.
  function automatic int m_inv(input int a, input int dg, input int pl, input int maxd);
    int am, r;
    if (dg == 0 || dg > maxd) return 0;
    am = a & ((1 << dg) - 1);
    if (dg == 1) return am;
    r = 1;
    for (int e = 0; e < (1 << dg) - 2; e++) r = m_mul(r, am, dg, pl);
    return r;
  endfunction

  function automatic int s_of(input int dg, input int maxd);
    return (dg >= 2 && dg <= maxd) ? dg - 1 : 1;
  endfunction

  task automatic send_a(input int dg, input int pl, input bit hi, input bit b2b);
    int msk;
    msk = (dg >= 1 && dg <= 5) ? ((1 << dg) - 1) : 31;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 || !b2b) @(negedge clk);
      ifa.in_valid = 1'b1;
      ifa.deg      = (i == 0) ? 3'(dg) : 3'($urandom);
      ifa.poly     = (i == 0) ? 6'(pl) : 6'($urandom);
      ifa.in_data  = 5'(din[i] | (hi ? (31 & ~msk) : 0));
    end
  endtask

  task automatic run_a(input int dg, input int pl, input bit hi, input bit b2b);
    int lat, exp, am;
    bit seen;
    send_a(dg, pl, hi, b2b);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ifa.in_valid = 1'b0;
        ifa.in_data  = 5'($urandom);
      end
      if (ifa.out_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check($sformatf("latency deg=%0d", dg), seen ? lat : -1, 4 * s_of(dg, 5) + 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      exp = m_inv(din[i], dg, pl, 5);
      check($sformatf("valid[%0d]", i), int'(ifa.out_valid), 1);
      check($sformatf("data[%0d] deg=%0d a=%0d", i, dg, din[i]), int'(ifa.out_data), exp);
      got[i] = int'(ifa.out_data);
`ifdef GF_INV_ERR_EN
      am = (dg >= 1 && dg <= 5) ? (din[i] & ((1 << dg) - 1)) : 0;
      check($sformatf("err[%0d]", i), int'(ifa.out_err), (am == 0) ? 1 : 0);
`else
      am = 0;
`endif
    end
    @(negedge clk);
    check("valid_end", int'(ifa.out_valid), 0);
    check("data_idle", int'(ifa.out_data), 0);
  endtask

  task automatic run_b(input int dg, input int pl, input int a);
    int lat;
    bit seen;
    @(negedge clk);
    ifb.in_valid = 1'b1;
    ifb.deg      = 4'(dg);
    ifb.poly     = 9'(pl);
    ifb.in_data  = 8'(a);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) ifb.in_valid = 1'b0;
      if (ifb.out_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check($sformatf("b latency deg=%0d", dg), seen ? lat : -1, s_of(dg, 8) + 1);
    check($sformatf("b data deg=%0d a=%0d", dg, a), int'(ifb.out_data), m_inv(a, dg, pl, 8));
    got[0] = int'(ifb.out_data);
    @(negedge clk);
    check("b valid_end", int'(ifb.out_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e1 [4];
    int highs;
    bit seen;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.deg = '0; ifa.poly = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.deg = '0; ifb.poly = '0;
    repeat (3) @(negedge clk);
    check("rst a valid", int'(ifa.out_valid), 0);
    check("rst a data", int'(ifa.out_data), 0);
    check("rst b valid", int'(ifb.out_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    din = '{1, 2, 3, 7};
    run_a(3, 11, 1'b0, 1'b0);
    e1 = '{1, 5, 6, 4};
    for (int i = 0; i < 4; i++) check($sformatf("gf8 lit[%0d]", i), got[i], e1[i]);

    din = '{2, 1, 0, 31};
    run_a(5, 37, 1'b0, 1'b0);
    check("gf32 inv2", got[0], 18);
    check("gf32 31*inv", m_mul(31, got[3], 5, 37), 1);

    din = '{3, 2, 1, 0};
    run_a(2, 7, 1'b1, 1'b0);
    e1 = '{2, 3, 1, 0};
    for (int i = 0; i < 4; i++) check($sformatf("gf4 lit[%0d]", i), got[i], e1[i]);

    for (int i = 0; i < 4; i++) din[i] = $urandom_range(1, 31);
    run_a(0, 37, 1'b0, 1'b0);
    run_a(6, 37, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) din[i] = $urandom_range(0, 31);
    run_a($urandom_range(1, 5), $urandom_range(0, 63), 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) din[i] = $urandom_range(0, 31);
      run_a($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 1) == 1, 1'b1);
    end

    // Reset during CALC aborts the burst.
    for (int i = 0; i < 4; i++) din[i] = $urandom_range(1, 7);
    send_a(3, 11, 1'b0, 1'b0);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst calc valid", int'(ifa.out_valid), 0);
    check("rst calc data", int'(ifa.out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.out_valid) highs++;
    end
    check("abort no output", highs, 0);

    // Reset while results are streaming clears outputs without a clock edge.
    din = '{7, 7, 7, 7};
    send_a(3, 11, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) ifa.in_valid = 1'b0;
      if (ifa.out_valid) seen = 1'b1;
    end
    check("out seen before rst", int'(seen), 1);
    rst = 1'b1;
    #1;
    check("rst out valid", int'(ifa.out_valid), 0);
    check("rst out data", int'(ifa.out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    din = '{2, 2, 2, 2};
    run_a(3, 11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("post rst[%0d]", i), got[i], 5);

    run_b(8, 'h11B, 'h53);
    check("aes inv 53", got[0], 'hCA);
    for (int n = 0; n < 5; n++) run_b($urandom_range(1, 8), $urandom_range(0, 511), $urandom_range(0, 255));
    run_b(0, 'h11B, 'h53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
